// File: rtl/cpu_imm_pkg.sv
// Shared RV32I definitions: immediate-format codes, opcodes and the encoder request struct.
// Used by the immediate encoder and the immediate generator.
package cpu_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_R = 3'b101;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int ENC_STAGES = 2;

  typedef struct packed {
    logic [2:0]  imm_type;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } imm_req_t;

endpackage

// File: rtl/imm_field_packer.sv
// Combinational RV32I field packer with encodability check.
// Range/alignment checks are enabled by ENCODER_RANGE_CHECK_EN.
module imm_field_packer
  import cpu_imm_pkg::*;
(
  input  imm_req_t    req,
  output logic [31:0] instr,
  output logic        err
);

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  logic        type_bad;
  logic        range_bad;
  logic [31:0] imm;

  assign imm = req.imm;

  always_comb begin
    instr     = '0;
    type_bad  = 1'b0;
    range_bad = 1'b0;
    unique case (req.imm_type)
      IMM_I: begin
        instr     = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_S: begin
        instr     = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
        range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_B: begin
        instr     = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                     imm[4:1], imm[11], req.opcode};
        range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      IMM_U: begin
        instr     = {imm[31:12], req.rd, req.opcode};
        range_bad = |imm[11:0];
      end
      IMM_J: begin
        instr     = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
        range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      IMM_R: begin
        instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      end
      default: type_bad = 1'b1;
    endcase
  end

  // A failing word still goes out with truncated fields; only the flag changes.
  assign err = type_bad | (RANGE_CHECK & range_bad);

endmodule

// File: rtl/immediate_encoder.sv
// Two-stage valid/ready RV32I instruction assembler with saturating error counter.
// Optional immediate range checking: define ENCODER_RANGE_CHECK_EN.
module immediate_encoder
  import cpu_imm_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_imm_type,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  imm_req_t                req;
  logic [31:0]             pk_instr;
  logic                    pk_err;
  logic [ENC_STAGES:1]     vld_pipe;
  logic [31:0]             s1_instr;
  logic                    s1_err;
  logic                    s2_ld;
  logic                    s1_ld;

  assign req = '{imm_type: in_imm_type, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                 rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  imm_field_packer u_pack (
    .req   (req),
    .instr (pk_instr),
    .err   (pk_err)
  );

  // Each stage loads when empty or when the stage after it drains this cycle.
  assign s2_ld     = !vld_pipe[2] || out_ready;
  assign s1_ld     = !vld_pipe[1] || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_instr  <= '0;
      s1_err    <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s2_ld) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_instr <= s1_instr;
          out_err   <= s1_err;
        end
      end
      if (s1_ld) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_instr <= pk_instr;
          s1_err   <= pk_err;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (out_valid && out_ready && out_err && !(&err_count))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed bench for immediate_encoder: encodings, errors, counter saturation,
// backpressure streaming and mid-operation reset.
module tb_immediate_encoder;
  import cpu_imm_pkg::*;

  localparam int CW = 2;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_imm_type = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  immediate_encoder #(.ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_type(in_imm_type), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_imm_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One word through an empty pipe: checks 2-cycle latency, word, flag and counter.
  task automatic enc(input string tag, input logic [2:0] t, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                     input logic [31:0] exp_instr, input logic exp_err);
    @(negedge clk);
    out_ready = 1'b1;
    drive(t, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, exp_instr);
    chk({tag, ".err"}, 32'(out_err), 32'(exp_err));
    if (exp_err && exp_cnt < (1 << CW) - 1) exp_cnt++;
    @(posedge clk); #1;
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    chk({tag, ".cnt"}, 32'(err_count), 32'(exp_cnt));
  endtask

  logic [31:0] got[$];
  int sent;
  bit saw_stall;

  initial begin
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_instr", out_instr, 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    enc("addi", IMM_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    enc("sw",   IMM_S, OPC_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0);
    enc("beq",  IMM_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    enc("jal",  IMM_J, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    enc("lui",  IMM_U, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    enc("sub",  IMM_R, OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    enc("i2048", IMM_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, RC);
    enc("inv6", 3'b110, OPC_OP_IMM, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'h0000_0001, 32'h0000_0000, 1'b1);
    enc("bmis", IMM_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0007, 32'h0000_0363, RC);
    enc("ulow", IMM_U, OPC_LUI,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_1037, RC);
    enc("inv7", 3'b111, OPC_LUI,   5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0000, 1'b1);
    enc("inv6b", 3'b110, OPC_LUI,  5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0000, 1'b1);
    enc("sat",  3'b111, OPC_LUI,   5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0000, 1'b1);

    // Stream 8 ADDIs with downstream stalled in cycles 3..6.
    sent = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      drive(IMM_I, OPC_OP_IMM, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent));
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got.push_back(out_instr);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream.stall", 32'(saw_stall), 32'd1);
    chk("stream.count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("stream.w%0d", i), (i < got.size()) ? got[i] : 32'hXXXX_XXXX,
          (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
    @(negedge clk); #1;
    chk("stream.extra", 32'(out_valid), 32'd0);

    // Fill both stages with backpressure, then reset asynchronously.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(3'b110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.err_count", 32'(err_count), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    exp_cnt = 0;
    enc("post", IMM_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
